// File: rtl/dpm_access_arbiter_pkg.sv
// ============================================================================
// Module   : dpm_pkg
// Brief    : Shared constants and state encoding for the 16x32 DPM arbiter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package dpm_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  localparam int unsigned c_PORT0 = 0;
  localparam int unsigned c_PORT1 = 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/dpm_access_arbiter_if.sv
// ============================================================================
// Module   : dpm_access_arbiter_if
// Brief    : Requester-side handshake bundle for both arbiter ports.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface dpm_access_arbiter_if;
  import dpm_pkg::*;

  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              rvalid0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              rvalid1;

  logic [DATA_W-1:0] rdata;

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    input  gnt0, rvalid0, gnt1, rvalid1, rdata
  );

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    output gnt0, rvalid0, gnt1, rvalid1, rdata
  );

endinterface

`default_nettype wire

// File: rtl/dpm_access_arbiter_rr_arb2.sv
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-requester round-robin arbiter; pointer holds last granted port.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arb2 (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic r_ptr;

  // On conflict the port that was not granted last wins.
  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        2'b11:   o_gnt = r_ptr ? 2'b01 : 2'b10;
        default: o_gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_ptr <= 1'b1;
    end else if (o_gnt[0]) begin
      r_ptr <= 1'b0;
    end else if (o_gnt[1]) begin
      r_ptr <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dpm_access_arbiter.sv
// ============================================================================
// Module   : dpm_access_arbiter
// Brief    : Shares DPM write/read ports between two requesters; clear sequencer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dpm_access_arbiter
  import dpm_pkg::*;
(
  input  logic                Clk,
  input  logic                Rst,
  dpm_access_arbiter_if.slave bus,
  input  logic                clr_req,
  output logic                clr_busy,
  output logic                clr_done,
  output logic                Wr_en,
  output logic [ADDR_W-1:0]   Wr_addr,
  output logic [DATA_W-1:0]   Data_in,
  output logic                Rd_en,
  output logic [ADDR_W-1:0]   Rd_addr,
  input  logic [DATA_W-1:0]   Mem_Data_out
);

  localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [1:0]        r_wr_gnt;
  logic [1:0]        r_rd_gnt;
  logic [1:0]        r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic              r_clr_busy;
  logic              r_clr_done;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_data_in;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;

  logic              w_arb_en;
  logic [1:0]        w_busy_gnt;
  logic [1:0]        w_wr_req;
  logic [1:0]        w_wr_gnt;
  logic [1:0]        w_rd_req;
  logic [1:0]        w_rd_gnt;
  logic              w_wr_any;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W-1:0] w_cnt_nxt;

  assign w_arb_en   = (r_state == ST_IDLE) && !clr_req;
  // A requester still sees its old request during its grant cycle; ignore it.
  assign w_busy_gnt = r_wr_gnt | r_rd_gnt;

  assign w_wr_req[c_PORT0] = bus.req0 & bus.we0 & ~w_busy_gnt[c_PORT0];
  assign w_wr_req[c_PORT1] = bus.req1 & bus.we1 & ~w_busy_gnt[c_PORT1];

  rr_arb2 u_wr_arb (
    .Clk   (Clk),
    .Rst   (Rst),
    .i_en  (w_arb_en),
    .i_req (w_wr_req),
    .o_gnt (w_wr_gnt)
  );

  assign w_wr_any  = |w_wr_gnt;
  assign w_wr_addr = w_wr_gnt[c_PORT1] ? bus.addr1  : bus.addr0;
  assign w_wr_data = w_wr_gnt[c_PORT1] ? bus.wdata1 : bus.wdata0;

  // Reads colliding with this cycle's write are held back so they return new data.
  assign w_rd_req[c_PORT0] = bus.req0 & ~bus.we0 & ~w_busy_gnt[c_PORT0] &
                             ~(w_wr_any && (bus.addr0 == w_wr_addr));
  assign w_rd_req[c_PORT1] = bus.req1 & ~bus.we1 & ~w_busy_gnt[c_PORT1] &
                             ~(w_wr_any && (bus.addr1 == w_wr_addr));

  rr_arb2 u_rd_arb (
    .Clk   (Clk),
    .Rst   (Rst),
    .i_en  (w_arb_en),
    .i_req (w_rd_req),
    .o_gnt (w_rd_gnt)
  );

  assign w_rd_addr = w_rd_gnt[c_PORT1] ? bus.addr1 : bus.addr0;
  assign w_cnt_nxt = r_clr_cnt + ADDR_W'(1);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state    <= ST_IDLE;
      r_clr_cnt  <= '0;
      r_wr_gnt   <= '0;
      r_rd_gnt   <= '0;
      r_rvalid   <= '0;
      r_rdata    <= '0;
      r_clr_busy <= 1'b0;
      r_clr_done <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_data_in  <= '0;
      r_rd_en    <= 1'b0;
      r_rd_addr  <= '0;
    end else begin
      // Read capture runs in every state so a read granted just before CLEAR completes.
      r_rvalid <= r_rd_gnt;
      if (r_rd_en) begin
        r_rdata <= Mem_Data_out;
      end

      case (r_state)
        ST_IDLE: begin
          r_wr_gnt   <= w_wr_gnt;
          r_rd_gnt   <= w_rd_gnt;
          r_wr_en    <= w_wr_any;
          r_rd_en    <= |w_rd_gnt;
          r_clr_done <= 1'b0;
          if (w_wr_any) begin
            r_wr_addr <= w_wr_addr;
            r_data_in <= w_wr_data;
          end
          if (|w_rd_gnt) begin
            r_rd_addr <= w_rd_addr;
          end
          if (clr_req) begin
            r_state    <= ST_CLEAR;
            r_clr_cnt  <= '0;
            r_clr_busy <= 1'b1;
            r_wr_en    <= 1'b1;
            r_wr_addr  <= '0;
            r_data_in  <= '0;
          end
        end

        ST_CLEAR: begin
          r_wr_gnt <= '0;
          r_rd_gnt <= '0;
          r_rd_en  <= 1'b0;
          if (r_clr_cnt == c_LAST) begin
            r_state    <= ST_IDLE;
            r_clr_busy <= 1'b0;
            r_clr_done <= 1'b0;
            r_wr_en    <= 1'b0;
          end else begin
            r_clr_cnt  <= w_cnt_nxt;
            r_wr_en    <= 1'b1;
            r_wr_addr  <= w_cnt_nxt;
            r_data_in  <= '0;
            r_clr_done <= (w_cnt_nxt == c_LAST);
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt0    = w_busy_gnt[c_PORT0];
  assign bus.gnt1    = w_busy_gnt[c_PORT1];
  assign bus.rvalid0 = r_rvalid[c_PORT0];
  assign bus.rvalid1 = r_rvalid[c_PORT1];
  assign bus.rdata   = r_rdata;

  assign clr_busy = r_clr_busy;
  assign clr_done = r_clr_done;
  assign Wr_en    = r_wr_en;
  assign Wr_addr  = r_wr_addr;
  assign Data_in  = r_data_in;
  assign Rd_en    = r_rd_en;
  assign Rd_addr  = r_rd_addr;

endmodule

`default_nettype wire
